jogador_automatico: RTL and testbench
=====================================

# jogador_automatico

Synthesizable automatic player for the memory-challenge game: it drives the game's `jogar` and `botoes` inputs and watches its `leds`, `ganhou` and `perdeu` outputs. Each round it records the LED sequence the game shows, replays it on the buttons, then enters one new item. It sits beside the game top level on the FPGA for self-test and soak runs, and can replace the bench-side player in simulation.

## Interface
Parameters:
- `PRESS_CYCLES`, default 10: clock cycles one button is held high.
- `GAP_CYCLES`, default 10: cycles with all buttons low after each release.
- `SETTLE_CYCLES`, default 8: cycles between the last LED turning off and the first press.
- `WATCHDOG_CYCLES`, default 2^20: maximum cycles without progress in any waiting state.

Ports:
- `clock`, in, 1: single clock. Everything is clocked on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `iniciar`, in, 1: start request. Level-sensitive, sampled only in OCIOSO.
- `modo`, in, 1: 1 = 4 rounds, 0 = 16 rounds. Latched on start.
- `leds`, in, 4: game LED outputs. One-hot or zero.
- `ganhou`, in, 1: game win indication.
- `perdeu`, in, 1: game loss indication.
- `jogar`, out, 1: start pulse to the game.
- `botoes`, out, 4: button drive. One-hot or zero.
- `ocupado`, out, 1: high in every state except OCIOSO, FIM and FALHA.
- `concluido`, out, 1: high in FIM.
- `falha`, out, 1: high in FALHA.
- `db_rodada`, out, 4: current round index, 0-based.
- `db_estado`, out, 4: state encoding.

## Operation
- Storage:
  - `seq`: 16 x 4-bit sequence buffer.
  - `rodada`: 4-bit round counter.
  - `idx`: 5-bit item index.
  - `cnt`: delay/watchdog counter.
  - `leds_q`: previous-cycle copy of `leds`.
  - `limite`: latched round limit, 3 or 15.
- States and encodings:
  - OCIOSO (0)
  - JOGAR (1)
  - OBSERVA (2)
  - ASSENTA (3)
  - PRESSIONA (4)
  - SOLTA (5)
  - NOVA_PRESSIONA (6)
  - NOVA_SOLTA (7)
  - AGUARDA_FIM (8)
  - FIM (9)
  - FALHA (15)
- OCIOSO: if `iniciar`=1, latch `limite`, clear `rodada` and `idx`, and go to JOGAR.
- JOGAR: drive `jogar`=1 for 2 cycles, then go to OBSERVA.
- OBSERVA, LED onset (`leds`≠0 and `leds_q`=0): write `seq[idx]`←`leds` and increment `idx`.
- OBSERVA, LED offset (`leds`=0 and `leds_q`≠0) with `idx`=`rodada`+1: clear `cnt` and go to ASSENTA.
- ASSENTA: wait `SETTLE_CYCLES`, clear `idx`, go to PRESSIONA.
- PRESSIONA: drive `botoes`=`seq[idx]` for `PRESS_CYCLES`, then go to SOLTA.
- SOLTA: drive `botoes`=0 for `GAP_CYCLES`, then increment `idx`. Exit depends on the new `idx`:
  - `idx`≤`rodada`: back to PRESSIONA.
  - `idx`=`rodada`+1 and `rodada`=`limite`: go to AGUARDA_FIM.
  - otherwise: go to NOVA_PRESSIONA.
- NOVA_PRESSIONA: the new item is `seq[rodada]` rotated left by 1 ({b2,b1,b0,b3}). Drive it for `PRESS_CYCLES`, then go to NOVA_SOLTA.
- NOVA_SOLTA: `GAP_CYCLES` low, then `rodada`++, `idx`←0, go to OBSERVA.
- AGUARDA_FIM: `ganhou`=1 goes to FIM; `perdeu`=1 goes to FALHA.
- FIM and FALHA: hold until `iniciar`=1, which restarts exactly as from OCIOSO.
- Global exits from any active state:
  - `perdeu`=1 goes to FALHA.
  - `ganhou`=1 outside AGUARDA_FIM goes to FALHA, because it is an unexpected win.
- OBSERVA protocol errors, both going to FALHA:
  - `leds` not one-hot and not zero.
  - More than `rodada`+1 onsets.
- Watchdog: `cnt` counts while in OBSERVA and AGUARDA_FIM and is cleared on every LED edge. Reaching `WATCHDOG_CYCLES` goes to FALHA.
- Widths:
  - `idx` is 5 bits so that the value 16 is representable.
  - `rodada` never exceeds `limite`; there is no wrap-around.

## Timing
- Reset values: state OCIOSO; `jogar`=0, `botoes`=0, `ocupado`=0, `concluido`=0, `falha`=0, `db_rodada`=0, `db_estado`=0.
- `seq` is not reset.
- Reset mid-operation returns to OCIOSO on the next edge and drives `botoes` to 0 in that cycle.
- All outputs are registered, so `botoes` never glitches.
- `botoes` is never nonzero for two consecutive items without at least `GAP_CYCLES` of zero between them.
- An LED edge is detected 1 cycle after `leds` changes.
- Delay to the first press: the ASSENTA entry follows the detected edge by 1 cycle, and the first press starts `SETTLE_CYCLES`+1 cycles after ASSENTA entry.
- Round `r` replay occupies (`r`+1)·(`PRESS_CYCLES`+`GAP_CYCLES`) cycles, plus one more PRESS+GAP if this is not the last round.
- `perdeu` and `ganhou` are evaluated every cycle. Priority order: `reset` > `perdeu` > `ganhou` > watchdog > normal transitions.
- `iniciar` held high in FIM restarts immediately; designs must debounce externally if that is not wanted.

## Test plan
- Full game, `modo`=1, game seeded 0001: 4 rounds pressing 0001 / 0001,0010 / …; `ganhou`=1, then `concluido`=1 and `db_rodada`=3.
- `modo`=0: 16 rounds completed. The new items cycle 0010,0100,1000,0001; FIM is reached.
- Game forced to assert `perdeu` during round 3 replay: `falha`=1 on the next cycle, `botoes`=0, `ocupado`=0.
- Game stalled after JOGAR with `WATCHDOG_CYCLES`=100: FALHA after 100 cycles. Then `iniciar`=1 restarts, `db_rodada`=0 and a `jogar` pulse is seen.
- `reset`=1 mid-PRESSIONA: next cycle `botoes`=0 and `db_estado`=0. A restart completes the 4-round game normally.
- `leds`=0011 injected in OBSERVA: FALHA.

Source files
------------

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: watches the LED sequence,
// replays it on the buttons, then enters one new item per round.
module jogador_automatico #(
  parameter int PRESS_CYCLES    = 10,
  parameter int GAP_CYCLES      = 10,
  parameter int SETTLE_CYCLES   = 8,
  parameter int WATCHDOG_CYCLES = 1 << 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       modo,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       concluido,
  output logic       falha,
  output logic [3:0] db_rodada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO         = 4'd0,
    JOGAR          = 4'd1,
    OBSERVA        = 4'd2,
    ASSENTA        = 4'd3,
    PRESSIONA      = 4'd4,
    SOLTA          = 4'd5,
    NOVA_PRESSIONA = 4'd6,
    NOVA_SOLTA     = 4'd7,
    AGUARDA_FIM    = 4'd8,
    FIM            = 4'd9,
    FALHA          = 4'd15
  } estado_t;

  localparam logic [31:0] PRESS_ULT = 32'(PRESS_CYCLES - 1);
  localparam logic [31:0] GAP_ULT   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] SETTLE_N  = 32'(SETTLE_CYCLES);
  localparam logic [31:0] WD_N      = 32'(WATCHDOG_CYCLES);

  estado_t     estado_q, estado_d;
  logic [3:0]  seq_q [16];
  logic [3:0]  rodada_q, rodada_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  leds_q;
  logic [3:0]  limite_q, limite_d;
  logic        seq_we;

  logic        jogar_q, ocupado_q, concluido_q, falha_q;
  logic [3:0]  botoes_q, botoes_d;
  logic [3:0]  db_rodada_q, db_estado_q;

  logic        onset, offset, ativo;
  logic [4:0]  alvo;
  logic [3:0]  nova;

  assign onset  = (leds != 4'd0) && (leds_q == 4'd0);
  assign offset = (leds == 4'd0) && (leds_q != 4'd0);
  assign alvo   = {1'b0, rodada_q} + 5'd1;
  assign ativo  = !(estado_q inside {OCIOSO, FIM, FALHA});

  always_comb begin
    estado_d = estado_q;
    rodada_d = rodada_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    limite_d = limite_q;
    seq_we   = 1'b0;
    unique case (estado_q)
      OCIOSO, FIM, FALHA: begin
        if (iniciar) begin
          limite_d = modo ? 4'd3 : 4'd15;
          rodada_d = 4'd0;
          idx_d    = 5'd0;
          cnt_d    = 32'd0;
          estado_d = JOGAR;
        end
      end
      JOGAR: begin
        if (cnt_q == 32'd1) begin
          cnt_d    = 32'd0;
          estado_d = OBSERVA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      OBSERVA: begin
        cnt_d = (onset || offset) ? 32'd0 : cnt_q + 32'd1;
        if (!$onehot0(leds)) begin
          estado_d = FALHA;
        end else if (onset) begin
          if (idx_q == alvo) begin
            estado_d = FALHA;
          end else begin
            seq_we = 1'b1;
            idx_d  = idx_q + 5'd1;
          end
        end else if (offset) begin
          if (idx_q == alvo) estado_d = ASSENTA;
        end else if (cnt_d == WD_N) begin
          estado_d = FALHA;
        end
      end
      ASSENTA: begin
        if (cnt_q == SETTLE_N) begin
          cnt_d    = 32'd0;
          idx_d    = 5'd0;
          estado_d = PRESSIONA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESSIONA, NOVA_PRESSIONA: begin
        if (cnt_q == PRESS_ULT) begin
          cnt_d    = 32'd0;
          estado_d = (estado_q == PRESSIONA) ? SOLTA : NOVA_SOLTA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SOLTA: begin
        if (cnt_q == GAP_ULT) begin
          cnt_d = 32'd0;
          idx_d = idx_q + 5'd1;
          if (idx_d <= {1'b0, rodada_q})
            estado_d = PRESSIONA;
          else if (rodada_q == limite_q)
            estado_d = AGUARDA_FIM;
          else
            estado_d = NOVA_PRESSIONA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      NOVA_SOLTA: begin
        if (cnt_q == GAP_ULT) begin
          cnt_d    = 32'd0;
          rodada_d = rodada_q + 4'd1;
          idx_d    = 5'd0;
          estado_d = OBSERVA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      AGUARDA_FIM: begin
        cnt_d = cnt_q + 32'd1;
        if (ganhou) estado_d = FIM;
        else if (cnt_d == WD_N) estado_d = FALHA;
      end
      default: estado_d = OCIOSO;
    endcase
    // Game verdicts outrank everything except reset
    if (ativo && perdeu) begin
      estado_d = FALHA;
      seq_we   = 1'b0;
    end else if (ativo && ganhou && estado_q != AGUARDA_FIM) begin
      estado_d = FALHA;
      seq_we   = 1'b0;
    end
  end

  assign nova = {seq_q[rodada_d][2:0], seq_q[rodada_d][3]};

  always_comb begin
    botoes_d = 4'd0;
    if (estado_d == PRESSIONA)      botoes_d = seq_q[idx_d[3:0]];
    if (estado_d == NOVA_PRESSIONA) botoes_d = nova;
  end

  always_ff @(posedge clock) begin
    if (seq_we && !reset) seq_q[idx_q[3:0]] <= leds;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      rodada_q    <= 4'd0;
      idx_q       <= 5'd0;
      cnt_q       <= 32'd0;
      leds_q      <= 4'd0;
      limite_q    <= 4'd3;
      jogar_q     <= 1'b0;
      botoes_q    <= 4'd0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      falha_q     <= 1'b0;
      db_rodada_q <= 4'd0;
      db_estado_q <= 4'd0;
    end else begin
      estado_q    <= estado_d;
      rodada_q    <= rodada_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      leds_q      <= leds;
      limite_q    <= limite_d;
      jogar_q     <= (estado_d == JOGAR);
      botoes_q    <= botoes_d;
      ocupado_q   <= !(estado_d inside {OCIOSO, FIM, FALHA});
      concluido_q <= (estado_d == FIM);
      falha_q     <= (estado_d == FALHA);
      db_rodada_q <= rodada_d;
      db_estado_q <= estado_d;
    end
  end

  assign jogar     = jogar_q;
  assign botoes    = botoes_q;
  assign ocupado   = ocupado_q;
  assign concluido = concluido_q;
  assign falha     = falha_q;
  assign db_rodada = db_rodada_q;
  assign db_estado = db_estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: plays the game side by hand
// and checks every press, gap, verdict and debug output.
module tb_jogador_automatico;

  localparam int P = 3;
  localparam int G = 2;
  localparam int S = 2;
  localparam int W = 100;

  logic       clk = 1'b0;
  logic       reset, iniciar, modo, ganhou, perdeu;
  logic [3:0] leds;
  logic       jogar, ocupado, concluido, falha;
  logic [3:0] botoes, db_rodada, db_estado;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jogador_automatico #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES(G),
    .SETTLE_CYCLES(S),
    .WATCHDOG_CYCLES(W)
  ) dut (
    .clock(clk),
    .reset(reset),
    .iniciar(iniciar),
    .modo(modo),
    .leds(leds),
    .ganhou(ganhou),
    .perdeu(perdeu),
    .jogar(jogar),
    .botoes(botoes),
    .ocupado(ocupado),
    .concluido(concluido),
    .falha(falha),
    .db_rodada(db_rodada),
    .db_estado(db_estado)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] item(input int k);
    logic [3:0] b;
    b = 4'b0001;
    return b << (k % 4);
  endfunction

  task automatic start_game(input logic m);
    int w;
    modo    = m;
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    check("start_rodada", 32'(db_rodada), 32'd0);
    w = 0;
    while (jogar && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("jogar_width", w, 2);
    check("observa_entry", 32'(db_estado), 32'd2);
  endtask

  task automatic show(input int r);
    for (int k = 0; k <= r; k++) begin
      leds = item(k);
      repeat (3) @(negedge clk);
      leds = 4'd0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic get_press(output logic [3:0] v, output int z,
                           output int w);
    z = 0;
    while (botoes == 4'd0 && z < 200) begin
      @(negedge clk);
      z++;
    end
    check("press_seen", 32'(z < 200), 32'd1);
    v = botoes;
    w = 0;
    while (botoes != 4'd0 && w < 200) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic play_round(input int r, input bit last);
    logic [3:0] v;
    int         z, w;
    show(r);
    for (int k = 0; k <= r; k++) begin
      get_press(v, z, w);
      check($sformatf("rep_val_r%0d_k%0d", r, k), 32'(v), 32'(item(k)));
      check("rep_width", w, P);
      if (k > 0) check("rep_gap", z, G);
    end
    if (!last) begin
      get_press(v, z, w);
      check($sformatf("new_val_r%0d", r), 32'(v), 32'(item(r + 1)));
      check("new_width", w, P);
      check("new_gap", z, G);
      repeat (3) @(negedge clk);
      check("next_round", 32'(db_rodada), 32'(r + 1));
      check("back_observa", 32'(db_estado), 32'd2);
    end else begin
      repeat (3) @(negedge clk);
      check("aguarda_fim", 32'(db_estado), 32'd8);
    end
  endtask

  task automatic play_game(input logic m);
    int nr;
    nr = m ? 4 : 16;
    start_game(m);
    for (int r = 0; r < nr; r++) play_round(r, r == nr - 1);
    ganhou = 1'b1;
    @(negedge clk);
    ganhou = 1'b0;
    check("concluido", 32'(concluido), 32'd1);
    check("fim_rodada", 32'(db_rodada), 32'(nr - 1));
    check("fim_ocupado", 32'(ocupado), 32'd0);
    check("fim_estado", 32'(db_estado), 32'd9);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset   = 1'b1;
    iniciar = 1'b0;
    modo    = 1'b1;
    leds    = 4'd0;
    ganhou  = 1'b0;
    perdeu  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_jogar", 32'(jogar), 32'd0);
    check("rst_botoes", 32'(botoes), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_concluido", 32'(concluido), 32'd0);
    check("rst_falha", 32'(falha), 32'd0);
    check("rst_rodada", 32'(db_rodada), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);

    play_game(1'b1);
    play_game(1'b0);

    // loss injected during the round-3 replay
    start_game(1'b1);
    for (int r = 0; r < 3; r++) play_round(r, 1'b0);
    show(3);
    n = 0;
    while (botoes == 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("r3_press_seen", 32'(botoes != 4'd0), 32'd1);
    perdeu = 1'b1;
    @(negedge clk);
    perdeu = 1'b0;
    check("perdeu_falha", 32'(falha), 32'd1);
    check("perdeu_botoes", 32'(botoes), 32'd0);
    check("perdeu_ocupado", 32'(ocupado), 32'd0);
    check("perdeu_estado", 32'(db_estado), 32'd15);

    // stalled game: watchdog
    start_game(1'b1);
    n = 0;
    while (!falha && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", n, W);
    check("wd_estado", 32'(db_estado), 32'd15);

    // restart, then reset while a button is held
    start_game(1'b1);
    show(0);
    n = 0;
    while (botoes == 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_press", 32'(botoes), 32'(item(0)));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_botoes", 32'(botoes), 32'd0);
    check("reset_estado", 32'(db_estado), 32'd0);
    play_game(1'b1);

    // malformed LED pattern
    start_game(1'b1);
    leds = 4'b0011;
    @(negedge clk);
    leds = 4'd0;
    check("leds_bad_falha", 32'(falha), 32'd1);
    check("leds_bad_estado", 32'(db_estado), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
